// File: rtl/spi_master_mc_if.sv
// rtl/spi_master_mc_if.sv - request, response and serial bus bundle for spi_master_mc
// Request side:  i_data, i_dv, i_ss_sel, i_cpol, i_cpha (controller -> master)
// Response side: o_ready, o_active, o_dv, o_data (master -> controller)
// Serial side:   o_sclk, o_mosi, o_ss_n out of the master, i_miso into it
// Modport master is the block itself; modport slave is the controller/bus side.
interface spi_master_mc_if #(
    parameter int p_WORD_LEN = 8,
    parameter int p_NUM_SS   = 2
);
    localparam int SEL_W = (p_NUM_SS > 1) ? $clog2(p_NUM_SS) : 1;

    logic [p_WORD_LEN-1:0] i_data;
    logic                  i_dv;
    logic [SEL_W-1:0]      i_ss_sel;
    logic                  i_cpol;
    logic                  i_cpha;
    logic                  i_miso;
    logic                  o_sclk;
    logic                  o_mosi;
    logic [p_NUM_SS-1:0]   o_ss_n;
    logic                  o_ready;
    logic                  o_active;
    logic                  o_dv;
    logic [p_WORD_LEN-1:0] o_data;

    modport master (
        input  i_data, i_dv, i_ss_sel, i_cpol, i_cpha, i_miso,
        output o_sclk, o_mosi, o_ss_n, o_ready, o_active, o_dv, o_data
    );

    modport slave (
        output i_data, i_dv, i_ss_sel, i_cpol, i_cpha, i_miso,
        input  o_sclk, o_mosi, o_ss_n, o_ready, o_active, o_dv, o_data
    );
endinterface

// File: rtl/spi_master_mc.sv
// rtl/spi_master_mc.sv - SPI master with word length, mode 0-3 and multi chip-select
// Ports: i_clk, i_rst (sync, active-high) and bus (spi_master_mc_if.master).
// A request is accepted in IDLE when i_dv=1 and i_ss_sel is in range; the
// transfer runs LEAD -> XFER -> TRAIL and ends with a one-cycle o_dv pulse.
module spi_master_mc #(
    parameter int p_WORD_LEN = 8,
    parameter int p_CLK_DIV  = 10,
    parameter int p_NUM_SS   = 2
) (
    input logic             i_clk,
    input logic             i_rst,
    spi_master_mc_if.master bus
);
    localparam int SEL_W  = (p_NUM_SS > 1) ? $clog2(p_NUM_SS) : 1;
    localparam int DIV_W  = $clog2(p_CLK_DIV);
    localparam int EDGE_W = $clog2(2 * p_WORD_LEN);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(p_CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * p_WORD_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEAD  = 2'd1;
    localparam logic [1:0] S_XFER  = 2'd2;
    localparam logic [1:0] S_TRAIL = 2'd3;

    logic [1:0]            state;
    logic [DIV_W-1:0]      div_cnt;
    logic [EDGE_W-1:0]     edge_cnt;
    logic                  cpol_r;
    logic                  cpha_r;
    logic                  sclk_r;
    logic                  mosi_r;
    logic [p_NUM_SS-1:0]   ss_n_r;
    logic                  dv_r;
    logic [p_WORD_LEN-1:0] data_r;
    logic [p_WORD_LEN-1:0] tx_sr;
    logic [p_WORD_LEN-1:0] rx_sr;

    logic                  sel_ok;
    logic [p_NUM_SS-1:0]   sel_mask;
    logic                  accept;
    logic                  half_done;
    logic                  fire;
    logic                  fire_lead;
    logic                  fire_last;
    logic                  do_sample;
    logic                  do_drive;

    always_comb begin
        sel_ok = (32'(bus.i_ss_sel) < p_NUM_SS);
        for (int i = 0; i < p_NUM_SS; i++) begin
            sel_mask[i] = (bus.i_ss_sel == SEL_W'(i));
        end
    end

    assign accept    = (state == S_IDLE) && bus.i_dv && sel_ok;
    assign half_done = (div_cnt == DIV_LAST);

    // An SCLK edge fires at the start of every XFER half-period. The first
    // comes from the end of LEAD; the rest from half-period wraps in XFER,
    // except after the final half-period, where SCLK is already back at idle.
    always_comb begin
        fire      = 1'b0;
        fire_lead = 1'b0;
        fire_last = 1'b0;
        if (state == S_LEAD && half_done) begin
            fire      = 1'b1;
            fire_lead = 1'b1;
        end else if (state == S_XFER && half_done && edge_cnt != EDGE_LAST) begin
            fire      = 1'b1;
            // Upcoming half-period index is edge_cnt+1; even indices are leading.
            fire_lead = edge_cnt[0];
            fire_last = (edge_cnt + 1'b1 == EDGE_LAST);
        end
    end

    // Sample on leading edges for cpha=0 and trailing edges for cpha=1; the
    // other edge drives. The final (trailing) edge never drives a new bit.
    assign do_sample = fire && (fire_lead ^ cpha_r);
    assign do_drive  = fire && !(fire_lead ^ cpha_r) && !fire_last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            cpol_r   <= 1'b0;
            cpha_r   <= 1'b0;
            sclk_r   <= 1'b0;
            mosi_r   <= 1'b0;
            ss_n_r   <= '1;
            dv_r     <= 1'b0;
            data_r   <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
        end else begin
            dv_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    cpol_r   <= bus.i_cpol;
                    sclk_r   <= bus.i_cpol;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    if (accept) begin
                        state  <= S_LEAD;
                        cpha_r <= bus.i_cpha;
                        ss_n_r <= ~sel_mask;
                        rx_sr  <= '0;
                        // cpha=0 presents the MSB before the first edge.
                        if (!bus.i_cpha) begin
                            mosi_r <= bus.i_data[p_WORD_LEN-1];
                            tx_sr  <= {bus.i_data[p_WORD_LEN-2:0], 1'b0};
                        end else begin
                            tx_sr  <= bus.i_data;
                        end
                    end
                end
                S_LEAD: begin
                    div_cnt <= half_done ? '0 : div_cnt + 1'b1;
                    if (half_done) begin
                        state <= S_XFER;
                    end
                end
                S_XFER: begin
                    div_cnt <= half_done ? '0 : div_cnt + 1'b1;
                    if (half_done) begin
                        if (edge_cnt == EDGE_LAST) begin
                            state <= S_TRAIL;
                        end else begin
                            edge_cnt <= edge_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    div_cnt <= half_done ? '0 : div_cnt + 1'b1;
                    if (half_done) begin
                        state  <= S_IDLE;
                        ss_n_r <= '1;
                        dv_r   <= 1'b1;
                        data_r <= rx_sr;
                    end
                end
            endcase

            if (fire) begin
                sclk_r <= ~sclk_r;
            end
            if (do_sample) begin
                rx_sr <= {rx_sr[p_WORD_LEN-2:0], bus.i_miso};
            end
            if (do_drive) begin
                mosi_r <= tx_sr[p_WORD_LEN-1];
                tx_sr  <= {tx_sr[p_WORD_LEN-2:0], 1'b0};
            end
        end
    end

    assign bus.o_sclk   = sclk_r;
    assign bus.o_mosi   = mosi_r;
    assign bus.o_ss_n   = ss_n_r;
    assign bus.o_ready  = (state == S_IDLE);
    assign bus.o_active = (state != S_IDLE);
    assign bus.o_dv     = dv_r;
    assign bus.o_data   = data_r;
endmodule

// File: tb/tb_spi_master_mc.sv
// tb/tb_spi_master_mc.sv - directed and randomized bench for spi_master_mc
// Three builds: defaults (a), three chip selects with fast clock (b), and
// 16-bit words with fast clock (c). A behavioural SPI slave serves build a.
module tb_spi_master_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    spi_master_mc_if #(.p_WORD_LEN(8),  .p_NUM_SS(2)) a ();
    spi_master_mc_if #(.p_WORD_LEN(8),  .p_NUM_SS(3)) b ();
    spi_master_mc_if #(.p_WORD_LEN(16), .p_NUM_SS(1)) c ();

    spi_master_mc #(.p_WORD_LEN(8),  .p_CLK_DIV(10), .p_NUM_SS(2)) dut_a (.i_clk(clk), .i_rst(rst), .bus(a));
    spi_master_mc #(.p_WORD_LEN(8),  .p_CLK_DIV(2),  .p_NUM_SS(3)) dut_b (.i_clk(clk), .i_rst(rst), .bus(b));
    spi_master_mc #(.p_WORD_LEN(16), .p_CLK_DIV(2),  .p_NUM_SS(1)) dut_c (.i_clk(clk), .i_rst(rst), .bus(c));

    // Behavioural slave for build a, driven purely by SCLK/SS_n events.
    logic       loopback;
    logic       s_en;
    logic       s_cpol;
    logic       s_cpha;
    int         s_sel;
    logic [7:0] s_word;
    logic [7:0] s_tx;
    logic [7:0] s_rx;
    logic       s_miso;

    assign a.i_miso = loopback ? a.o_mosi : s_miso;
    assign b.i_miso = b.o_mosi;
    assign c.i_miso = c.o_mosi;

    always @(a.o_ss_n) begin
        if (s_en && a.o_ss_n[s_sel] === 1'b0) begin
            s_tx = s_word;
            s_rx = 8'h00;
            if (!s_cpha) begin
                s_miso = s_tx[7];
                s_tx   = {s_tx[6:0], 1'b0};
            end
        end
    end

    always @(a.o_sclk) begin
        if (s_en && a.o_ss_n[s_sel] === 1'b0) begin
            if ((a.o_sclk != s_cpol) ^ s_cpha) begin
                s_rx = {s_rx[6:0], a.o_mosi};
            end else begin
                s_miso = s_tx[7];
                s_tx   = {s_tx[6:0], 1'b0};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer on build a, checked against the SPI rules: chip select
    // timing, 8 leading SCLK edges, MOSI spelling the word at the slave's
    // sample edges, and o_dv exactly once at cycle 181 with the right word.
    task automatic xfer_a(input string tag, input logic [7:0] data, input int sel,
                          input logic cpol, input logic cpha, input bit use_slave,
                          input logic [7:0] sword, input bit inject);
        int         bad_ss;
        int         bad_rdy;
        int         leads;
        int         dv_cnt;
        int         dv_cyc;
        logic [7:0] dv_data;
        logic [1:0] ss_at_dv;
        logic       rdy_at_dv;
        logic [7:0] mosi_word;
        logic       prev_sclk;
        logic [1:0] exp_mask;
        bad_ss = 0; bad_rdy = 0; leads = 0; dv_cnt = 0; dv_cyc = -1;
        dv_data = 8'h00; ss_at_dv = 2'b00; rdy_at_dv = 1'b0; mosi_word = 8'h00;
        exp_mask = (sel == 0) ? 2'b10 : 2'b01;

        loopback = !use_slave;
        s_en = use_slave; s_cpol = cpol; s_cpha = cpha; s_sel = sel; s_word = sword;
        a.i_cpol = cpol;
        a.i_cpha = cpha;
        step();
        chk({tag, "_idle_sclk"}, 32'(a.o_sclk), 32'(cpol));
        chk({tag, "_idle_ss"}, 32'(a.o_ss_n), 32'h3);

        a.i_data = data;
        a.i_ss_sel = 1'(sel);
        a.i_dv = 1'b1;
        step();
        a.i_dv = 1'b0;
        if (inject) a.i_data = 8'h00;
        prev_sclk = cpol;
        for (int cyc = 1; cyc <= 195; cyc++) begin
            if (cyc < 181) begin
                if (a.o_ss_n !== exp_mask) bad_ss++;
                if (a.o_ready !== 1'b0 || a.o_active !== 1'b1) bad_rdy++;
            end
            if (a.o_sclk !== prev_sclk) begin
                if (a.o_sclk !== cpol) leads++;
                if ((a.o_sclk !== cpol) ^ cpha) mosi_word = {mosi_word[6:0], a.o_mosi};
                prev_sclk = a.o_sclk;
            end
            if (a.o_dv === 1'b1) begin
                dv_cnt++;
                if (dv_cyc < 0) begin
                    dv_cyc = cyc; dv_data = a.o_data; ss_at_dv = a.o_ss_n; rdy_at_dv = a.o_ready;
                end
            end
            if (inject && cyc == 49) begin a.i_dv = 1'b1; a.i_data = 8'h00; end
            if (inject && cyc == 50) a.i_dv = 1'b0;
            step();
        end
        chk({tag, "_ss_during"}, 32'(bad_ss), 32'd0);
        chk({tag, "_busy_during"}, 32'(bad_rdy), 32'd0);
        chk({tag, "_lead_edges"}, 32'(leads), 32'd8);
        chk({tag, "_mosi_word"}, 32'(mosi_word), 32'(data));
        chk({tag, "_dv_count"}, 32'(dv_cnt), 32'd1);
        chk({tag, "_dv_cycle"}, 32'(dv_cyc), 32'd181);
        chk({tag, "_rx_data"}, 32'(dv_data), use_slave ? 32'(sword) : 32'(data));
        chk({tag, "_ss_at_dv"}, 32'(ss_at_dv), 32'h3);
        chk({tag, "_ready_at_dv"}, 32'(rdy_at_dv), 32'd1);
        if (use_slave) chk({tag, "_slave_rx"}, 32'(s_rx), 32'(data));
        s_en = 1'b0;
    endtask

    initial begin
        int         cyc;
        int         bad;
        int         dvs;
        logic [15:0] w16;
        rst = 1'b1;
        loopback = 1'b1; s_en = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; s_sel = 0;
        s_word = 8'h00; s_tx = 8'h00; s_rx = 8'h00; s_miso = 1'b0;
        a.i_data = '0; a.i_dv = 1'b0; a.i_ss_sel = '0; a.i_cpol = 1'b0; a.i_cpha = 1'b0;
        b.i_data = '0; b.i_dv = 1'b0; b.i_ss_sel = '0; b.i_cpol = 1'b0; b.i_cpha = 1'b0;
        c.i_data = '0; c.i_dv = 1'b0; c.i_ss_sel = '0; c.i_cpol = 1'b0; c.i_cpha = 1'b0;
        step();
        step();
        chk("rst_ss_n", 32'(a.o_ss_n), 32'h3);
        chk("rst_sclk", 32'(a.o_sclk), 32'h0);
        chk("rst_mosi", 32'(a.o_mosi), 32'h0);
        chk("rst_ready", 32'(a.o_ready), 32'h1);
        chk("rst_active", 32'(a.o_active), 32'h0);
        chk("rst_dv", 32'(a.o_dv), 32'h0);
        chk("rst_data", 32'(a.o_data), 32'h0);
        chk("rst_b_ss_n", 32'(b.o_ss_n), 32'h7);
        rst = 1'b0;
        step();

        // Mode 0 loopback, then modes 1-3 against the slave on select 1.
        xfer_a("m0_f0", 8'hF0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        xfer_a("m1", 8'hB4, 1, 1'b0, 1'b1, 1'b1, 8'h69, 1'b0);
        xfer_a("m2", 8'h1E, 1, 1'b1, 1'b0, 1'b1, 8'h69, 1'b0);
        xfer_a("m3", 8'hD2, 1, 1'b1, 1'b1, 1'b1, 8'h69, 1'b0);

        // Randomized modes, selects and words against the slave model.
        for (int n = 0; n < 6; n++) begin
            logic [1:0] mode;
            mode = 2'($urandom_range(0, 3));
            xfer_a($sformatf("rnd%0d", n), 8'($urandom), int'($urandom_range(0, 1)),
                   mode[1], mode[0], 1'b1, 8'($urandom), 1'b0);
        end

        // Request during a transfer, with i_data changed mid-transfer.
        xfer_a("busy_ign", 8'hC3, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset part way through a transfer.
        loopback = 1'b1;
        a.i_cpol = 1'b0; a.i_cpha = 1'b0; a.i_data = 8'h5A; a.i_ss_sel = 1'b0; a.i_dv = 1'b1;
        step();
        a.i_dv = 1'b0;
        repeat (89) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_ss_n", 32'(a.o_ss_n), 32'h3);
        chk("mid_rst_sclk", 32'(a.o_sclk), 32'h0);
        chk("mid_rst_ready", 32'(a.o_ready), 32'h1);
        chk("mid_rst_data", 32'(a.o_data), 32'h0);
        dvs = 0;
        for (int i = 0; i < 200; i++) begin
            if (a.o_dv === 1'b1) dvs++;
            step();
        end
        chk("mid_rst_no_dv", 32'(dvs), 32'd0);
        xfer_a("post_rst", 8'h81, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Back-to-back requests.
        loopback = 1'b1;
        a.i_cpol = 1'b0; a.i_cpha = 1'b0;
        step();
        a.i_data = 8'hA5; a.i_ss_sel = 1'b0; a.i_dv = 1'b1;
        step();
        a.i_dv = 1'b0;
        cyc = 1;
        while (a.o_dv !== 1'b1 && cyc < 400) begin step(); cyc++; end
        chk("b2b_dv1_cycle", 32'(cyc), 32'd181);
        chk("b2b_dv1_data", 32'(a.o_data), 32'hA5);
        chk("b2b_gap_ss_n", 32'(a.o_ss_n), 32'h3);
        a.i_data = 8'h3C; a.i_dv = 1'b1;
        step();
        cyc++;
        a.i_dv = 1'b0;
        chk("b2b_next_ss_n", 32'(a.o_ss_n), 32'h2);
        while (a.o_dv !== 1'b1 && cyc < 800) begin step(); cyc++; end
        chk("b2b_dv2_cycle", 32'(cyc), 32'd362);
        chk("b2b_dv2_data", 32'(a.o_data), 32'h3C);

        // Out-of-range select on the three-select build, then a valid one.
        b.i_ss_sel = 2'd3; b.i_data = 8'h96; b.i_dv = 1'b1;
        bad = 0; dvs = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (b.o_ss_n !== 3'b111 || b.o_ready !== 1'b1) bad++;
            if (b.o_dv === 1'b1) dvs++;
        end
        chk("oor_ss_ready", 32'(bad), 32'd0);
        chk("oor_no_dv", 32'(dvs), 32'd0);
        b.i_ss_sel = 2'd2;
        step();
        b.i_dv = 1'b0;
        chk("b_sel2_ss_n", 32'(b.o_ss_n), 32'h3);
        cyc = 1;
        while (b.o_dv !== 1'b1 && cyc < 200) begin step(); cyc++; end
        chk("b_dv_cycle", 32'(cyc), 32'd37);
        chk("b_rx_data", 32'(b.o_data), 32'h96);

        // 16-bit build with two-cycle half-periods.
        w16 = 16'($urandom);
        c.i_data = w16; c.i_ss_sel = 1'b0; c.i_dv = 1'b1;
        step();
        c.i_dv = 1'b0;
        chk("c_ss_n", 32'(c.o_ss_n), 32'h0);
        cyc = 1;
        while (c.o_dv !== 1'b1 && cyc < 300) begin step(); cyc++; end
        chk("c_dv_cycle", 32'(cyc), 32'd69);
        chk("c_rx_data", 32'(c.o_data), 32'(w16));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
Parametrised SPI master, successor to the single-mode spi_master. Adds a configurable word length, runtime-selectable SPI mode (CPOL/CPHA, modes 0-3), p_NUM_SS active-low chip selects driven by the block, an explicit ready/valid request handshake and a receive-valid strobe. It sits between a local controller and one SPI bus shared by up to p_NUM_SS slaves such as spi_slave.

Parameters:
p_WORD_LEN, 8, bits per transfer, at least 2.
p_CLK_DIV, 10, i_clk cycles per SCLK half-period, at least 2.
p_NUM_SS, 2, number of chip-select outputs, at least 1.
(local) SEL_W = max(1, $clog2(p_NUM_SS)).

Ports:
i_clk  in  1  system clock; all logic on its rising edge.
i_rst  in  1  synchronous, active-high reset.
i_data  in  p_WORD_LEN  word to transmit, MSB first.
i_dv  in  1  request strobe; accepted only while o_ready=1.
i_ss_sel  in  SEL_W  index of the slave to address.
i_cpol  in  1  SCLK idle level for the request.
i_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
i_miso  in  1  serial data from slave.
o_sclk  out  1  SPI clock.
o_mosi  out  1  serial data to slave.
o_ss_n  out  p_NUM_SS  active-low chip selects; at most one low.
o_ready  out  1  high in IDLE.
o_active  out  1  high while a transfer is in progress (not IDLE).
o_dv  out  1  one-cycle pulse when o_data is valid.
o_data  out  p_WORD_LEN  received word; holds until the next o_dv.

Behaviour:
- Reset, applied in any state including mid-transfer: next cycle state=IDLE, o_ss_n all 1, o_sclk=0, o_mosi=0, o_ready=1, o_active=0, o_dv=0, o_data=0, internal cpol=0, counters 0.
- States and transitions:
  - IDLE -> LEAD: on i_dv=1 with i_ss_sel < p_NUM_SS.
  - LEAD -> XFER: after p_CLK_DIV cycles.
  - XFER -> TRAIL: after 2*p_WORD_LEN half-periods.
  - TRAIL -> IDLE: after p_CLK_DIV cycles.
- IDLE:
  - Internal cpol register loads i_cpol every cycle; o_sclk = that register.
  - On acceptance, latch i_data, i_ss_sel, i_cpol and i_cpha. Later changes to these inputs have no effect until the next acceptance.
- Out-of-range select (i_ss_sel >= p_NUM_SS): request ignored; stay in IDLE; no o_dv; no o_ss_n asserted.
- i_dv while o_ready=0 is ignored; no queuing.
- Acceptance cycle = cycle 0. From cycle 1:
  - o_ss_n[sel]=0, o_ready=0, o_active=1.
  - o_mosi = data MSB if cpha=0, otherwise it holds its previous value.
- LEAD: p_CLK_DIV cycles, o_sclk at idle level.
- XFER: 2*p_WORD_LEN half-periods of p_CLK_DIV cycles each.
  - o_sclk toggles at the start of each half-period. The odd-numbered edges (1st, 3rd, …) are leading edges; the even-numbered edges are trailing edges.
  - cpha=0: sample i_miso on each leading edge; on each trailing edge except the last, drive the next data bit onto o_mosi.
  - cpha=1: on each leading edge, drive the next data bit onto o_mosi (MSB first); sample i_miso on each trailing edge.
  - Sampled bits shift in MSB first.
- TRAIL: p_CLK_DIV cycles, o_sclk at idle level, o_ss_n still asserted.
- Completion cycle T = 1 + (2*p_WORD_LEN + 2)*p_CLK_DIV, which is 181 for the defaults. At cycle T:
  - o_ss_n all 1, o_dv=1, o_data = received word.
  - o_ready=1, o_active=0.
  - o_mosi holds the last bit.
- Back-to-back: i_dv at cycle T is accepted. o_ss_n is then high for exactly that one cycle and the next transfer's LEAD starts at T+1.
- cpol applies for the whole transfer from its latched value. A mode change between transfers takes effect on o_sclk in IDLE, before any o_ss_n assertion.
- Counters: the half-period counter runs 0..p_CLK_DIV-1 and wraps; the edge counter runs 0..2*p_WORD_LEN-1. Both are sized with $clog2 and must not overflow for any legal parameter values.

Test Plan:
1. Mode 0, defaults, i_miso tied to o_mosi; i_dv with i_data=8'hF0, sel=0:
   - o_ss_n=2'b10 from cycle 1 to 180.
   - 8 rising edges on o_sclk; o_mosi sequence 1,1,1,1,0,0,0,0 is stable at each rising edge.
   - o_dv at cycle 181 with o_data=8'hF0.
2. Modes 1, 2, 3, with a bench slave returning 8'h69 on sel=1:
   - o_ss_n=2'b01.
   - o_sclk idles at cpol; in every mode the data edge precedes the sample edge.
   - o_data=8'h69 and the slave receives the sent word.
3. Out-of-range select, p_NUM_SS=3, i_ss_sel=3:
   - o_ss_n stays 3'b111, o_ready stays 1, no o_dv.
4. i_dv pulsed at cycle 50 of a transfer, with i_data changed to 8'h00 during the transfer:
   - ignored; the current transfer returns its original word; only one o_dv.
5. i_rst asserted at cycle 90:
   - next cycle o_ss_n all 1, o_sclk=0, o_ready=1, o_data=0, no o_dv.
   - a new request then completes normally.
6. Back-to-back requests (8'hA5 then 8'h3C, sel 0), plus a p_WORD_LEN=16, p_CLK_DIV=2 build:
   - first pair: o_ss_n high for exactly 1 cycle between the two transfers; o_dv at 181 and 362.
   - 16-bit build: o_dv at cycle 1 + 34*2 = 69.
